hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Generates operand-forwarding selects for the ID-stage register-file read ports (qa/qb), load-use stalls and bubbles, and sequences the multi-cycle mult/div unit (MDU) with a busy FSM.
- Counts stall cycles for performance debug.
- Sits beside the register file in ID. The register file writes on the negative clock edge, so WB-stage results are already visible on qa/qb. Only EX and MEM results are forwarded.

Parameters:
- MDU_LATENCY, 4, cycles an MDU operation occupies the unit (legal range >= 2)
- CNT_W, 16, width of the stall-cycle performance counter

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  5  ID source register A
- id_rt  in  5  ID source register B
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_is_mdu  in  1  instruction is mult/multu/div/divu
- id_is_mfhilo  in  1  instruction is mfhi/mflo
- ex_wreg  in  1  EX instruction writes a register
- ex_m2reg  in  1  EX instruction is a load
- ex_dest  in  5  EX destination register
- mem_wreg  in  1  MEM instruction writes a register
- mem_m2reg  in  1  MEM instruction is a load
- mem_dest  in  5  MEM destination register
- fwd_a  out  2  qa source select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
- fwd_b  out  2  qb source select, same encoding as fwd_a
- stall  out  1  hold PC and IF/ID register
- bubble  out  1  load a nop into ID/EX
- mdu_start  out  1  launch MDU this cycle
- mdu_busy  out  1  MDU occupied
- mdu_done  out  1  one-cycle pulse; HI/LO are written at the end of this cycle
- stall_cnt  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Reset (asynchronous): FSM goes to IDLE, latency counter = 0, stall_cnt = 0. While reset is high, every output is 0.
- Reset asserted mid-MDU-operation aborts the operation with no mdu_done pulse.
- Register 0 never matches a hazard: any dest == 0 is ignored.
- Forwarding (combinational), per port, using rs for fwd_a and rt for fwd_b:
  - If uses && ex_wreg && !ex_m2reg && ex_dest == src: select 01.
  - Else if uses && mem_wreg && mem_dest == src: select 11 when mem_m2reg, else 10.
  - Else: select 00.
  - EX has priority over MEM for the same register.
- Load-use hazard (combinational), lu: id_valid && ex_wreg && ex_m2reg && ex_dest != 0 && ((id_uses_rs && ex_dest == id_rs) || (id_uses_rt && ex_dest == id_rt)). It causes exactly one stall cycle; the next cycle the load is in MEM and forwards via 11.
- MDU FSM, states IDLE and BUSY:
  - mdu_hz = id_valid && (id_is_mdu || id_is_mfhilo) && state == BUSY.
  - stall = lu || mdu_hz. bubble = stall.
  - mdu_start = id_valid && id_is_mdu && !stall. A start can only occur in IDLE.
  - IDLE -> BUSY on mdu_start, counter loaded with MDU_LATENCY-1.
  - In BUSY, counter decrements each cycle. mdu_busy = 1.
  - mdu_done = 1 in BUSY when counter == 0; the next state is IDLE.
  - An op started at edge t (mdu_start high in cycle t) gives mdu_busy in cycles t+1..t+MDU_LATENCY and mdu_done in cycle t+MDU_LATENCY.
  - mfhi/mflo or a new MDU op in ID stalls through the done cycle and proceeds in the cycle after it.
  - Non-MDU instructions are never stalled by BUSY.
- Simultaneous lu and mdu_hz: a single stall; both conditions are re-evaluated each cycle.
- stall_cnt increments at each posedge where stall = 1. It saturates at all-ones and does not wrap.
- All state updates on posedge clk.

Test Plan:
- add $3 in EX, ID reads rs=$3 -> fwd_a=01, stall=0. Same add in MEM -> fwd_a=10. $3 in both EX and MEM -> fwd_a=01.
- lw $5 in EX, ID reads rt=$5 -> stall=1, bubble=1 for one cycle. Next cycle (lw in MEM) -> fwd_b=11, stall=0, stall_cnt=1.
- ex_dest=0 with ex_wreg=1, ID reads $0 -> fwd_a=00, no stall.
- mult issued in cycle t (MDU_LATENCY=4) -> mdu_start at t, mdu_busy t+1..t+4, mdu_done at t+4 only. mfhi in ID from t+1 -> stall t+1..t+4, released at t+5, stall_cnt=4.
- Back-to-back div then mult -> second held until the cycle after mdu_done, then mdu_start=1. Unrelated add during BUSY -> no stall.
- Assert reset at t+2 of an MDU op -> outputs 0 immediately, FSM IDLE, no mdu_done. Force 2^CNT_W+5 stall cycles -> stall_cnt holds all-ones.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage forwarding selects, load-use and MDU stalls, MDU busy
// sequencing and a saturating stall-cycle counter for the 5-stage MIPS core.
`default_nettype none

module hazard_ctrl #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_mdu,
  input  logic             id_is_mfhilo,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [4:0]       ex_dest,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [4:0]       mem_dest,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             bubble,
  output logic             mdu_start,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int CW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       lu, mdu_hz, stall_w, start_w, done_w;
  logic [1:0] fwd_a_w, fwd_b_w;

  // WB results are visible through the negedge-write regfile, so only EX/MEM forward.
  function automatic logic [1:0] fwd_sel(
    input logic       uses,
    input logic [4:0] src,
    input logic       exw,
    input logic       exl,
    input logic [4:0] exd,
    input logic       memw,
    input logic       meml,
    input logic [4:0] memd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (uses && exw && !exl && exd != 5'd0 && exd == src)
      sel = 2'b01;
    else if (uses && memw && memd != 5'd0 && memd == src)
      sel = meml ? 2'b11 : 2'b10;
    return sel;
  endfunction

  always_comb begin
    fwd_a_w = fwd_sel(id_uses_rs, id_rs, ex_wreg, ex_m2reg, ex_dest,
                      mem_wreg, mem_m2reg, mem_dest);
    fwd_b_w = fwd_sel(id_uses_rt, id_rt, ex_wreg, ex_m2reg, ex_dest,
                      mem_wreg, mem_m2reg, mem_dest);

    lu = id_valid && ex_wreg && ex_m2reg && (ex_dest != 5'd0) &&
         ((id_uses_rs && ex_dest == id_rs) || (id_uses_rt && ex_dest == id_rt));
    mdu_hz  = id_valid && (id_is_mdu || id_is_mfhilo) && (state_q == BUSY);
    stall_w = lu || mdu_hz;
    start_w = id_valid && id_is_mdu && !stall_w;
    done_w  = (state_q == BUSY) && (cnt_q == '0);

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_w) begin
          state_d = BUSY;
          cnt_d   = CW'(MDU_LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (stall_w && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign fwd_a     = reset ? 2'b00 : fwd_a_w;
  assign fwd_b     = reset ? 2'b00 : fwd_b_w;
  assign stall     = !reset && stall_w;
  assign bubble    = !reset && stall_w;
  assign mdu_start = !reset && start_w;
  assign mdu_busy  = !reset && (state_q == BUSY);
  assign mdu_done  = !reset && done_w;
  assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire
